// File: rtl/montgomery_wrapper.sv
// montgomery_wrapper: command-driven wrapper around two lockstep radix-2 Montgomery multipliers.
module montgomery_core #(
  parameter int WORD_LEN = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [WORD_LEN-1:0] a_i,
  input  logic [WORD_LEN-1:0] b_i,
  input  logic [WORD_LEN-1:0] m_i,
  output logic                done_o,
  output logic [WORD_LEN-1:0] r_o
);
  localparam int CW = $clog2(WORD_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD_LEN);
  logic [WORD_LEN+1:0] c_q, c_add, c_odd, b_x, m_x;
  logic [WORD_LEN-1:0] a_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  assign b_x    = {2'b00, b_i};
  assign m_x    = {2'b00, m_i};
  assign c_add  = c_q + (a_q[0] ? b_x : '0);
  assign c_odd  = c_add + (c_add[0] ? m_x : '0);
  assign done_o = busy_q && cnt_q == LAST;
  // the accumulator stays below 2M, so one conditional subtract finishes the reduction
  assign r_o    = WORD_LEN'(c_q >= m_x ? c_q - m_x : c_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= '0;
      a_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      c_q    <= '0;
      a_q    <= a_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (done_o) busy_q <= 1'b0;
      else begin
        c_q   <= c_odd >> 1;
        a_q   <= a_q >> 1;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

module montgomery_wrapper #(
  parameter int WORD_LEN = 512
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [WORD_LEN-1:0] bram_din1,
  input  logic [WORD_LEN-1:0] bram_din2,
  input  logic                bram_din_valid,
  output logic [WORD_LEN-1:0] bram_dout1,
  output logic [WORD_LEN-1:0] bram_dout2,
  output logic                bram_dout1_valid,
  output logic                bram_dout2_valid,
  input  logic                bram_dout_read,
  input  logic [31:0]         port1_din,
  input  logic                port1_valid,
  output logic                port1_read,
  output logic                port2_valid,
  input  logic                port2_read,
  output logic [3:0]          leds
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ_A  = 3'd1;
  localparam logic [2:0] READ_B  = 3'd2;
  localparam logic [2:0] READ_M  = 3'd3;
  localparam logic [2:0] COMPUTE = 3'd4;
  localparam logic [2:0] WRITE   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  logic [2:0]          state_q, state_d, cmd;
  logic [WORD_LEN-1:0] a1_q, b1_q, m1_q, a2_q, b2_q, m2_q, r1_q, r2_q, dout1_q, dout2_q;
  logic [WORD_LEN-1:0] res1, res2;
  logic                done1, done2, start, p1_read_q, p2_valid_q, dout_valid_q;
  assign cmd   = port1_din[2:0];
  assign start = state_q == IDLE && port1_valid && cmd == 3'd3;
  montgomery_core #(.WORD_LEN(WORD_LEN)) u_core1 (
    .clk(clk), .rst(resetn), .start_i(start), .a_i(a1_q), .b_i(b1_q), .m_i(m1_q),
    .done_o(done1), .r_o(res1)
  );
  montgomery_core #(.WORD_LEN(WORD_LEN)) u_core2 (
    .clk(clk), .rst(resetn), .start_i(start), .a_i(a2_q), .b_i(b2_q), .m_i(m2_q),
    .done_o(done2), .r_o(res2)
  );
  // command codes 0..4 map onto state codes 1..5; anything else is a no-op
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:                   state_d = port1_valid ? (cmd > 3'd4 ? DONE : cmd + 3'd1) : IDLE;
      READ_A, READ_B, READ_M: state_d = bram_din_valid ? DONE : state_q;
      COMPUTE:                state_d = (done1 && done2) ? DONE : COMPUTE;
      WRITE:                  state_d = bram_dout_read ? DONE : WRITE;
      DONE:                   state_d = port2_read ? IDLE : DONE;
      default:                state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= IDLE;
      p1_read_q    <= 1'b0;
      p2_valid_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      dout1_q      <= '0;
      dout2_q      <= '0;
      a1_q         <= '0;
      b1_q         <= '0;
      m1_q         <= '0;
      a2_q         <= '0;
      b2_q         <= '0;
      m2_q         <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
    end else begin
      state_q      <= state_d;
      p1_read_q    <= state_q == IDLE && port1_valid;
      p2_valid_q   <= state_d == DONE;
      dout_valid_q <= state_d == WRITE;
      if (state_q == IDLE && state_d == WRITE) begin
        dout1_q <= r1_q;
        dout2_q <= r2_q;
      end
      if (state_q == READ_A && bram_din_valid) begin
        a1_q <= bram_din1;
        a2_q <= bram_din2;
      end
      if (state_q == READ_B && bram_din_valid) begin
        b1_q <= bram_din1;
        b2_q <= bram_din2;
      end
      if (state_q == READ_M && bram_din_valid) begin
        m1_q <= bram_din1;
        m2_q <= bram_din2;
      end
      if (state_q == COMPUTE && done1 && done2) begin
        r1_q <= res1;
        r2_q <= res2;
      end
    end
  end
  assign bram_dout1       = dout1_q;
  assign bram_dout2       = dout2_q;
  assign bram_dout1_valid = dout_valid_q;
  assign bram_dout2_valid = dout_valid_q;
  assign port1_read       = p1_read_q;
  assign port2_valid      = p2_valid_q;
  assign leds             = {1'b0, state_q};
endmodule

// File: tb/tb_montgomery_wrapper.sv
// tb_montgomery_wrapper: directed scoreboard bench for the dual Montgomery wrapper.
module tb_montgomery_wrapper;
  localparam int W = 512;
  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [W-1:0] bram_din1 = '0, bram_din2 = '0, bram_dout1, bram_dout2;
  logic         bram_din_valid = 1'b0, bram_dout_read = 1'b0;
  logic         bram_dout1_valid, bram_dout2_valid;
  logic [31:0]  port1_din = '0;
  logic         port1_valid = 1'b0, port1_read, port2_valid, port2_read = 1'b0;
  logic [3:0]   leds;
  int           n_chk = 0, n_fail = 0;
  logic [2*W-1:0] sb_q[$];

  montgomery_wrapper #(.WORD_LEN(W)) dut (
    .clk(clk), .resetn(resetn),
    .bram_din1(bram_din1), .bram_din2(bram_din2), .bram_din_valid(bram_din_valid),
    .bram_dout1(bram_dout1), .bram_dout2(bram_dout2),
    .bram_dout1_valid(bram_dout1_valid), .bram_dout2_valid(bram_dout2_valid),
    .bram_dout_read(bram_dout_read),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .port2_valid(port2_valid), .port2_read(port2_read), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // modular product by double-and-add, then W modular halvings
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+1:0] x, mx;
    x  = '0;
    mx = {2'b00, m};
    for (int i = W - 1; i >= 0; i--) begin
      x = x << 1;
      if (x >= mx) x = x - mx;
      if (b[i]) x = x + {2'b00, a};
      if (x >= mx) x = x - mx;
    end
    for (int i = 0; i < W; i++) begin
      if (x[0]) x = x + mx;
      x = x >> 1;
    end
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_cmd(input logic [2:0] c, input logic [3:0] exp_leds);
    port1_din   = {29'd0, c};
    port1_valid = 1'b1;
    step();
    port1_valid = 1'b0;
    chk("p1_read_pulse", W'(port1_read), W'(1));
    chk("leds_after_cmd", W'(leds), W'(exp_leds));
  endtask

  task automatic ack();
    int n;
    n = 0;
    while (!port2_valid && n < 2000) begin
      step();
      n++;
    end
    chk("p2_valid_seen", W'(port2_valid), W'(1));
    port2_read = 1'b1;
    step();
    port2_read = 1'b0;
    chk("p2_valid_clear", W'(port2_valid), W'(0));
    chk("leds_idle", W'(leds), W'(0));
  endtask

  task automatic load(input logic [2:0] c, input logic [W-1:0] d1, input logic [W-1:0] d2);
    send_cmd(c, 4'(c) + 4'd1);
    bram_din1      = d1;
    bram_din2      = d2;
    bram_din_valid = 1'b1;
    step();
    bram_din_valid = 1'b0;
    chk("leds_done", W'(leds), W'(6));
    ack();
  endtask

  task automatic compute(output int n);
    send_cmd(3'd3, 4'd4);
    n = 1;
    while (!port2_valid && n < 2000) begin
      step();
      n++;
    end
    ack();
  endtask

  task automatic do_write();
    logic [2*W-1:0] exp;
    send_cmd(3'd4, 4'd5);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : '0;
    for (int i = 0; i < 3; i++) begin
      chk("dout1_valid", W'(bram_dout1_valid), W'(1));
      chk("dout2_valid", W'(bram_dout2_valid), W'(1));
      step();
    end
    chk("dout1", bram_dout1, exp[2*W-1:W]);
    chk("dout2", bram_dout2, exp[W-1:0]);
    bram_dout_read = 1'b1;
    step();
    bram_dout_read = 1'b0;
    chk("dout_valid_clear", W'({bram_dout1_valid, bram_dout2_valid}), W'(0));
    chk("dout1_retained", bram_dout1, exp[2*W-1:W]);
    chk("p2_after_write", W'(port2_valid), W'(1));
    ack();
  endtask

  initial begin
    logic [W-1:0] a1, b1, m1, a2, b2, m2, r1, r2;
    int n;
    bit seen;
    #1;
    chk("reset_leds", W'(leds), W'(0));
    chk("reset_outs", W'({port1_read, port2_valid, bram_dout1_valid, bram_dout2_valid}), W'(0));
    step();
    step();
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("idle_p1_read", W'(port1_read), W'(0));
    chk("idle_leds", W'(leds), W'(0));
    chk("idle_dout", bram_dout1 | bram_dout2, '0);

    send_cmd(3'd0, 4'd1);
    step();
    chk("p1_read_drop", W'(port1_read), W'(0));
    chk("read_a_wait", W'(leds), W'(1));
    bram_din1 = W'(5);
    bram_din2 = W'(7);
    bram_din_valid = 1'b1;
    step();
    bram_din_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("p2_held", W'(port2_valid), W'(1));
    ack();

    m1 = rnd(); m1[W-1] = 1'b1; m1[0] = 1'b1;
    m2 = rnd(); m2[W-1] = 1'b1; m2[0] = 1'b1;
    a1 = rnd(); a1[W-1] = 1'b0;
    a2 = rnd(); a2[W-1] = 1'b0;
    b1 = rnd(); b1[W-1] = 1'b0;
    b2 = rnd(); b2[W-1] = 1'b0;
    load(3'd0, a1, a2);
    load(3'd1, b1, b2);
    load(3'd2, m1, m2);
    compute(n);
    chk("latency_range", W'(n >= 513 && n <= 520), W'(1));
    r1 = mont(a1, b1, m1);
    r2 = mont(a2, b2, m2);
    sb_q.push_back({r1, r2});
    do_write();

    load(3'd0, '0, '0);
    compute(n);
    chk("latency_zero_a", W'(n >= 513 && n <= 520), W'(1));
    sb_q.push_back('0);
    do_write();

    load(3'd0, a2, a1);
    load(3'd1, b2, b1);
    load(3'd2, m2, m1);
    compute(n);
    r1 = mont(a2, b2, m2);
    r2 = mont(a1, b1, m1);
    sb_q.push_back({r1, r2});
    do_write();

    send_cmd(3'd7, 4'd6);
    chk("nop_p2_valid", W'(port2_valid), W'(1));
    step();
    chk("nop_p1_read_drop", W'(port1_read), W'(0));
    ack();
    sb_q.push_back({r1, r2});
    do_write();

    send_cmd(3'd3, 4'd4);
    for (int i = 0; i < 100; i++) step();
    resetn = 1'b1;
    #1;
    chk("abort_outs", W'({port1_read, port2_valid, bram_dout1_valid, bram_dout2_valid, leds}), W'(0));
    chk("abort_dout", bram_dout1 | bram_dout2, '0);
    step();
    resetn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      seen |= port2_valid;
    end
    chk("abort_no_p2", W'(seen), W'(0));
    sb_q.push_back('0);
    do_write();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/montgomery_wrapper.md
MONTGOMERY_WRAPPER -- requirements
Module: montgomery_wrapper

Interface
REQ-001 Parameter: WORD_LEN, default 512, operand/result width in bits.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 resetn  in  1  asynchronous, active-high reset; 1 = reset asserted.
REQ-004 bram_din1, bram_din2  in  WORD_LEN  operand data for core 1 / core 2.
REQ-005 bram_din_valid  in  1  din1/din2 valid this cycle.
REQ-006 bram_dout1, bram_dout2  out  WORD_LEN  result of core 1 / core 2.
REQ-007 bram_dout1_valid, bram_dout2_valid  out  1  corresponding dout holds a result.
REQ-008 bram_dout_read  in  1  consumer has taken both results.
REQ-009 port1_din  in  32  command word; port1_valid  in  1  command present; port1_read  out  1  command accepted.
REQ-010 port2_valid  out  1  command complete; port2_read  in  1  host acknowledges completion.
REQ-011 leds  out  4  current FSM state code (REQ-013 encoding).

Function
REQ-012 Two identical Montgomery cores; core k computes Rk = Ak*Bk*2^-WORD_LEN mod Mk; preconditions Mk odd, Ak<Mk, Bk<Mk.
REQ-013 FSM states/codes: IDLE=0, READ_A=1, READ_B=2, READ_M=3, COMPUTE=4, WRITE=5, DONE=6.
REQ-014 IDLE: on edge with port1_valid=1, latch port1_din[2:0]; go to state by command: 0->READ_A, 1->READ_B, 2->READ_M, 3->COMPUTE, 4->WRITE, any other value->DONE (no-op).
REQ-015 port1_read is registered, high for exactly the one cycle following the accepting edge; port1_valid ignored outside IDLE.
REQ-016 READ_A/B/M: on first edge with bram_din_valid=1, capture din1 into A1/B1/M1 and din2 into A2/B2/M2; go to DONE; wait indefinitely otherwise.
REQ-017 COMPUTE: start both cores on entry; go to DONE when both report done.
REQ-018 Core algorithm, radix-2 bit-serial: C=0; for i=0..WORD_LEN-1: if A[i] C+=B; if C odd C+=M; C>>=1; finally if C>=M C-=M; C held in WORD_LEN+2 bits.
REQ-019 Core latency: WORD_LEN iteration cycles + 1 correction cycle (513 for 512); both cores run in lockstep.
REQ-020 Result registers R1/R2 updated only at core completion; retain value until next COMPUTE or reset.
REQ-021 WRITE: drive bram_dout1=R1, bram_dout2=R2, assert both dout valids (registered) and hold until an edge samples bram_dout_read=1; then clear both valids, go to DONE.
REQ-022 bram_dout1/2 keep their last value after valids drop.
REQ-023 DONE: port2_valid=1 (registered), held until an edge samples port2_read=1; then port2_valid=0, go to IDLE.
REQ-024 port2_read ignored outside DONE; bram_dout_read ignored outside WRITE; bram_din_valid ignored outside READ states.
REQ-025 One command in flight; a new command is accepted only after return to IDLE.
REQ-026 COMPUTE without prior loads uses current register contents (zeros after reset -> result 0).

Reset
REQ-027 resetn=1 immediately forces IDLE, clears A/B/M/R registers, core state, all outputs to 0 (port1_read, port2_valid, dout valids, dout data, leds).
REQ-028 Reset mid-operation (any state, including COMPUTE) aborts it with no completion signalled; operation resumes on first edge after resetn=0.

Verification
REQ-029 Reset then idle -> all outputs 0, leds=0, port1_read stays 0 with port1_valid=0.
REQ-030 Cmd 0, then din1=5,din2=7 with valid -> port1_read one-cycle pulse, port2_valid held until port2_read, leds returns to 0.
REQ-031 Load A1=0x9383…31dd, B1=0x8414…ec2a, M1=0xdc40…6875; A2=0xd172…9ed0, B2=0x87de…daa3, M2=0xa4d3…673d; cmd 3, cmd 4 -> bram_dout1=0x7bd8…2a74, bram_dout2=0x92c8…a186, both valids high together until bram_dout_read.
REQ-032 A=0, any B, M=odd; multiply, write -> both results 0; port2_valid asserted 513..520 cycles after cmd 3 acceptance.
REQ-033 Cmd 7 -> port1_read pulse, immediate DONE, port2_valid; no register changes.
REQ-034 Assert resetn during COMPUTE -> port2_valid never rises; outputs 0; subsequent cmd 4 returns zeros.
